// File: rtl/jb_srx_req_sched.sv
// SRX control-stream request scheduler: round-robin antenna/path requests with
// interleaved VSWR rounds, switch confirmation via srx_tuser and beat-counted dwell.
module jb_srx_req_sched #(
   parameter int N_ANTENNAS = 4,
   parameter int MIN_WAIT   = 4
) (
   input  logic                  axis_aclk,
   input  logic                  axis_aresetn,
   input  logic                  enable,
   input  logic [N_ANTENNAS-1:0] ant_mask,
   input  logic [15:0]           dwell_len,
   input  logic [15:0]           settle_timeout,
   input  logic [3:0]            vswr_every,
   output logic                  m_srx_ctrl_tvalid,
   input  logic                  m_srx_ctrl_tready,
   output logic [7:0]            m_srx_ctrl_tdata,
   input  logic [7:0]            srx_tuser,
   input  logic                  srx_tvalid,
   input  logic                  srx_tready,
   output logic [2:0]            cur_ant,
   output logic [3:0]            cur_type,
   output logic                  capture_active,
   output logic                  round_done,
   output logic                  timeout_err,
   output logic [15:0]           timeout_cnt,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_REQUEST,
      S_WAIT_SWITCH,
      S_DWELL,
      S_RELEASE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cur_ant_q, cur_ant_d;
   logic [3:0]  cur_type_q, cur_type_d;
   logic [2:0]  last_ant_q, last_ant_d;
   logic [3:0]  round_cnt_q, round_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [15:0] beat_cnt_q, beat_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;
   logic        round_done_q, round_done_d;

   logic [2:0]  low_ant, after_ant, high_ant, pick_ant;
   logic        has_after, has_any;
   logic        match, beat;
   logic [15:0] dwell_last;
   logic        unused_tuser;

   assign unused_tuser = ^srx_tuser[7:3];

   // Next pick is the first enabled antenna above last_ant, else wrap to the lowest.
   always_comb begin
      low_ant   = '0;
      after_ant = '0;
      high_ant  = '0;
      has_after = 1'b0;
      has_any   = 1'b0;
      for (int k = 0; k < N_ANTENNAS; k++) begin
         if (ant_mask[k]) begin
            if (!has_any) low_ant = 3'(k);
            if (!has_after && (3'(k) > last_ant_q)) begin
               after_ant = 3'(k);
               has_after = 1'b1;
            end
            has_any  = 1'b1;
            high_ant = 3'(k);
         end
      end
      pick_ant = has_after ? after_ant : low_ant;
   end

   assign match      = (srx_tuser[2:0] == cur_ant_q) && (wait_cnt_q >= 16'(MIN_WAIT));
   assign beat       = srx_tvalid & srx_tready;
   assign dwell_last = (dwell_len == 16'd0) ? 16'd0 : dwell_len - 16'd1;

   always_comb begin
      state_d           = state_q;
      cur_ant_d         = cur_ant_q;
      cur_type_d        = cur_type_q;
      last_ant_d        = last_ant_q;
      round_cnt_d       = round_cnt_q;
      wait_cnt_d        = wait_cnt_q;
      beat_cnt_d        = beat_cnt_q;
      timeout_cnt_d     = timeout_cnt_q;
      round_done_d      = 1'b0;
      timeout_err       = 1'b0;
      m_srx_ctrl_tvalid = 1'b0;
      m_srx_ctrl_tdata  = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (enable && (ant_mask != '0)) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (!enable || (ant_mask == '0)) begin
               state_d    = S_RELEASE;
               cur_type_d = 4'hF;
            end else begin
               cur_ant_d  = pick_ant;
               cur_type_d = ((vswr_every != 4'd0) && (round_cnt_q == vswr_every)) ? 4'h2 : 4'h0;
               state_d    = S_REQUEST;
            end
         end
         S_REQUEST: begin
            m_srx_ctrl_tvalid = 1'b1;
            m_srx_ctrl_tdata  = {cur_type_q, 1'b0, cur_ant_q};
            if (m_srx_ctrl_tready) begin
               state_d    = S_WAIT_SWITCH;
               wait_cnt_d = 16'd0;
            end
         end
         S_WAIT_SWITCH: begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            if (match) begin
               state_d    = S_DWELL;
               beat_cnt_d = 16'd0;
            end else if ((settle_timeout != 16'd0) && (wait_cnt_q == settle_timeout)) begin
               timeout_err   = 1'b1;
               timeout_cnt_d = (timeout_cnt_q == 16'hFFFF) ? timeout_cnt_q : timeout_cnt_q + 16'd1;
               last_ant_d    = cur_ant_q;
               if (enable) begin
                  state_d = S_SELECT;
               end else begin
                  state_d    = S_RELEASE;
                  cur_type_d = 4'hF;
               end
            end
         end
         S_DWELL: begin
            if (beat) begin
               if (beat_cnt_q == dwell_last) begin
                  last_ant_d = cur_ant_q;
                  // The round ends on the highest enabled antenna; a VSWR round restarts the count.
                  if (has_any && (cur_ant_q == high_ant)) begin
                     round_done_d = 1'b1;
                     if (cur_type_q == 4'h2) round_cnt_d = 4'd0;
                     else if (round_cnt_q != 4'hF) round_cnt_d = round_cnt_q + 4'd1;
                  end
                  if (enable) begin
                     state_d = S_SELECT;
                  end else begin
                     state_d    = S_RELEASE;
                     cur_type_d = 4'hF;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 16'd1;
               end
            end
         end
         S_RELEASE: begin
            m_srx_ctrl_tvalid = 1'b1;
            m_srx_ctrl_tdata  = 8'hF0;
            if (m_srx_ctrl_tready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q       <= S_IDLE;
         cur_ant_q     <= '0;
         cur_type_q    <= '0;
         last_ant_q    <= 3'(N_ANTENNAS - 1);
         round_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         beat_cnt_q    <= '0;
         timeout_cnt_q <= '0;
         round_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_ant_q     <= cur_ant_d;
         cur_type_q    <= cur_type_d;
         last_ant_q    <= last_ant_d;
         round_cnt_q   <= round_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         beat_cnt_q    <= beat_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         round_done_q  <= round_done_d;
      end
   end

   assign cur_ant        = cur_ant_q;
   assign cur_type       = cur_type_q;
   assign capture_active = (state_q == S_DWELL);
   assign round_done     = round_done_q;
   assign timeout_cnt    = timeout_cnt_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_jb_srx_req_sched.sv
// Scoreboard bench for jb_srx_req_sched: a plan model predicts every request, switch
// latency, timeout and round end; a negedge monitor pops and compares.
module tb_jb_srx_req_sched;

   localparam int N      = 4;
   localparam int SETTLE = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  ant_mask = 4'd0;
   logic [15:0] dwell_len = 16'd1;
   logic [15:0] settle_timeout = 16'(SETTLE);
   logic [3:0]  vswr_every = 4'd0;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic [7:0]  m_tdata;
   logic [7:0]  srx_tuser;
   logic        srx_tvalid = 1'b0;
   logic        srx_tready = 1'b0;
   logic [2:0]  cur_ant;
   logic [3:0]  cur_type;
   logic        capture_active;
   logic        round_done;
   logic        timeout_err;
   logic [15:0] timeout_cnt;
   logic        busy;

   always #5 clk = ~clk;

   jb_srx_req_sched #(.N_ANTENNAS(N), .MIN_WAIT(4)) dut (
      .axis_aclk        (clk),
      .axis_aresetn     (rst_n),
      .enable           (enable),
      .ant_mask         (ant_mask),
      .dwell_len        (dwell_len),
      .settle_timeout   (settle_timeout),
      .vswr_every       (vswr_every),
      .m_srx_ctrl_tvalid(m_tvalid),
      .m_srx_ctrl_tready(m_tready),
      .m_srx_ctrl_tdata (m_tdata),
      .srx_tuser        (srx_tuser),
      .srx_tvalid       (srx_tvalid),
      .srx_tready       (srx_tready),
      .cur_ant          (cur_ant),
      .cur_type         (cur_type),
      .capture_active   (capture_active),
      .round_done       (round_done),
      .timeout_err      (timeout_err),
      .timeout_cnt      (timeout_cnt),
      .busy             (busy)
   );

   typedef struct {
      logic [7:0] tdata;
      bit         timed_out;
      bit         round_end;
      int         latency;
   } exp_t;

   typedef struct {
      bit ignore;
      int delay;
   } resp_t;

   exp_t  exp_q[$];
   resp_t resp_q[$];
   int    total = 0;
   int    bad = 0;
   int    hs_count = 0;
   int    plan_len = 0;
   int    dwell_exp = 1;
   int    exp_timeouts = 0;
   bit    ready_hold = 1'b0;
   logic [2:0] tuser_ant = 3'd0;

   assign srx_tuser = {5'b00000, tuser_ant};

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Responder model plus random backpressure and sample-stream gaps.
   initial begin : responder
      int    grant_cnt;
      logic [2:0] grant_ant;
      resp_t r;
      grant_cnt = 0;
      grant_ant = 3'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            grant_cnt = 0;
         end else if (m_tvalid && m_tready && (m_tdata[7:4] != 4'hF)) begin
            if (resp_q.size() == 0) begin
               check_output("responder request within plan", hs_count, plan_len);
            end else begin
               r = resp_q.pop_front();
               if (!r.ignore) begin
                  grant_cnt = r.delay + 1;
                  grant_ant = m_tdata[2:0];
               end
            end
         end
         @(posedge clk);
         #1;
         if (grant_cnt > 0) begin
            grant_cnt--;
            if (grant_cnt == 0) tuser_ant = grant_ant;
         end
         m_tready   = ready_hold ? 1'b0 : ($urandom_range(0, 99) < 70);
         srx_tvalid = ($urandom_range(0, 99) < 60);
         srx_tready = ($urandom_range(0, 99) < 80);
      end
   end

   // Monitor: every request handshake pops the scoreboard; switch/dwell timing checked per request.
   initial begin : monitor
      exp_t       cur_exp;
      bit         track, prev_pending, prev_cap, fall;
      int         age, beats;
      logic [7:0] prev_data;
      cur_exp = '{8'h00, 1'b0, 1'b0, 0};
      track = 1'b0; prev_pending = 1'b0; prev_cap = 1'b0;
      age = 0; beats = 0; prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            track = 1'b0; prev_pending = 1'b0; prev_cap = 1'b0;
            age = 0; beats = 0; hs_count = 0;
         end else begin
            if (prev_pending) begin
               check_output("tvalid held until ready", 32'(m_tvalid), 32'd1);
               check_output("tdata stable while stalled", 32'(m_tdata), 32'(prev_data));
            end
            if (track) age++;
            if (timeout_err) begin
               check_output("timeout_err only when due", 32'(track && cur_exp.timed_out), 32'd1);
               if (track) check_output("timeout_err cycle", 32'(age), 32'(SETTLE + 1));
               track = 1'b0;
            end else if (track && (age > SETTLE + 4)) begin
               check_output("switch resolved", 32'(age), 32'(cur_exp.latency));
               track = 1'b0;
            end
            if (capture_active && !prev_cap) begin
               check_output("dwell entered when due", 32'(track && !cur_exp.timed_out), 32'd1);
               if (track) check_output("switch latency", 32'(age), 32'(cur_exp.latency));
               track = 1'b0;
               beats = 0;
            end
            if (capture_active && srx_tvalid && srx_tready) beats++;
            fall = prev_cap && !capture_active;
            if (fall) begin
               check_output("dwell beats", 32'(beats), 32'(dwell_exp));
               check_output("round_done at dwell end", 32'(round_done), 32'(cur_exp.round_end));
            end else if (round_done) begin
               check_output("round_done spurious", 32'(round_done), 32'd0);
            end
            prev_cap     = capture_active;
            prev_pending = m_tvalid && !m_tready;
            prev_data    = m_tdata;
            if (m_tvalid && m_tready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  check_output("request count within plan", 32'(hs_count), 32'(plan_len));
               end else begin
                  cur_exp = exp_q.pop_front();
                  check_output("request tdata", 32'(m_tdata), 32'(cur_exp.tdata));
                  if (cur_exp.tdata[7:4] != 4'hF) begin
                     track = 1'b1;
                     age   = 0;
                  end
               end
            end
         end
      end
   end

   // Reference plan: round-robin order, VSWR interleave, timeouts and round ends from the rules.
   task automatic build_plan(input logic [3:0] mask, input int k_req, input logic [15:0] ignore_bits,
                             input logic [3:0] ve, input int delay_mode);
      int         last, rc, hi, ant, typ, d;
      logic [2:0] tu;
      bit         to;
      exp_t       e;
      resp_t      r;
      last = N - 1; rc = 0; hi = 0; tu = tuser_ant;
      exp_timeouts = 0;
      for (int k = 0; k < N; k++) if (mask[k]) hi = k;
      for (int i = 0; i < k_req; i++) begin
         ant = -1;
         for (int j = 1; j <= N; j++) if (ant < 0 && mask[(last + j) % N]) ant = (last + j) % N;
         typ = ((ve != 0) && (rc == int'(ve))) ? 2 : 0;
         d   = (delay_mode == 0) ? int'($urandom_range(1, 8)) : delay_mode;
         to  = ignore_bits[i] && (3'(ant) != tu);
         e.tdata     = {4'(typ), 1'b0, 3'(ant)};
         e.timed_out = to;
         e.round_end = !to && (ant == hi);
         e.latency   = (3'(ant) == tu) ? 6 : (((d > 4) ? d : 4) + 2);
         if (to) begin
            exp_timeouts++;
         end else begin
            tu = 3'(ant);
            if (ant == hi) rc = (typ == 2) ? 0 : ((rc < 15) ? rc + 1 : 15);
         end
         last = ant;
         exp_q.push_back(e);
         r.ignore = ignore_bits[i];
         r.delay  = d;
         resp_q.push_back(r);
      end
      e = '{8'hF0, 1'b0, 1'b0, 0};
      exp_q.push_back(e);
      plan_len = k_req + 1;
   endtask

   task automatic check_zeros(input string tag);
      check_output({tag, " tvalid"}, 32'(m_tvalid), 32'd0);
      check_output({tag, " tdata"}, 32'(m_tdata), 32'd0);
      check_output({tag, " cur_ant"}, 32'(cur_ant), 32'd0);
      check_output({tag, " cur_type"}, 32'(cur_type), 32'd0);
      check_output({tag, " capture_active"}, 32'(capture_active), 32'd0);
      check_output({tag, " round_done"}, 32'(round_done), 32'd0);
      check_output({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
      check_output({tag, " timeout_cnt"}, 32'(timeout_cnt), 32'd0);
      check_output({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ready_hold = 1'b0;
      exp_q.delete();
      resp_q.delete();
      repeat (12) @(posedge clk);
      #1;
      check_zeros("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_hs(input int n);
      for (int c = 0; c < 3000 && hs_count < n; c++) begin
         @(posedge clk);
         #1;
      end
      if (hs_count < n) check_output("handshake count", 32'(hs_count), 32'(n));
   endtask

   task automatic finish_test(input int k_req, input bit hold);
      int c;
      if (hold) begin
         wait_hs(k_req - 1);
         ready_hold = 1'b1;
         for (c = 0; c < 3000 && !m_tvalid; c++) begin
            @(posedge clk);
            #1;
         end
         if (!m_tvalid) check_output("stalled request presented", 32'(m_tvalid), 32'd1);
         repeat (5) @(posedge clk);
         #1;
         enable = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         ready_hold = 1'b0;
      end
      wait_hs(k_req);
      enable = 1'b0;
      for (c = 0; c < 3000 && busy; c++) begin
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check_output("busy low after release", 32'(busy), 32'd0);
      check_output("all planned requests issued", 32'(exp_q.size()), 32'd0);
      check_output("timeout_cnt", 32'(timeout_cnt), 32'(exp_timeouts));
   endtask

   task automatic apply_stimulus(input logic [3:0] mask, input int dwell, input logic [3:0] ve,
                                 input int k_req, input logic [15:0] ignore_bits, input bit hold,
                                 input int delay_mode);
      enable     = 1'b0;
      ant_mask   = mask;
      dwell_len  = 16'(dwell);
      vswr_every = ve;
      do_reset();
      dwell_exp = (dwell == 0) ? 1 : dwell;
      build_plan(mask, k_req, ignore_bits, ve, delay_mode);
      enable = 1'b1;
      finish_test(k_req, hold);
   endtask

   task automatic reset_test(input int phase);
      int c;
      enable     = 1'b0;
      ant_mask   = 4'b1011;
      dwell_len  = 16'd4;
      vswr_every = 4'd0;
      do_reset();
      dwell_exp = 4;
      build_plan(4'b1011, 10, 16'h0000, 4'd0, 0);
      enable = 1'b1;
      if (phase == 0) begin
         for (c = 0; c < 3000 && !capture_active; c++) begin
            @(posedge clk);
            #1;
         end
      end else begin
         wait_hs(2);
         repeat (2) @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zeros((phase == 0) ? "reset in dwell" : "reset in wait");
      exp_q.delete();
      resp_q.delete();
      ant_mask = 4'b1110;
      repeat (12) @(posedge clk);
      #1;
      build_plan(4'b1110, 3, 16'h0000, 4'd0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      finish_test(3, 1'b0);
   endtask

   initial begin : watchdog
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [15:0] ign;
      int          k_req;
      apply_stimulus(4'b1011, 3, 4'd0, 4, 16'h0000, 1'b0, 6);
      apply_stimulus(4'b0001, 2, 4'd2, 6, 16'h0000, 1'b0, 6);
      apply_stimulus(4'b0011, 2, 4'd0, 3, 16'h0000, 1'b1, 0);
      apply_stimulus(4'b1011, 2, 4'd0, 4, 16'h0002, 1'b0, 6);
      apply_stimulus(4'b0100, 1, 4'd0, 3, 16'h0000, 1'b0, 1);
      reset_test(0);
      reset_test(1);
      for (int r = 0; r < 6; r++) begin
         k_req = $urandom_range(4, 10);
         ign   = 16'h0000;
         for (int i = 0; i < k_req; i++) if ($urandom_range(0, 4) == 0) ign[i] = 1'b1;
         apply_stimulus(4'($urandom_range(1, 15)), $urandom_range(0, 4), 4'($urandom_range(0, 3)),
                        k_req, ign, 1'b0, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
